product_bcd_conv: RTL and testbench

Reads the 14-bit signed product held by the multiplier's product register and converts it to sign plus packed BCD digits for the display path. It uses a sequential shift-and-add-3 (double-dabble) converter with a start/busy/done handshake. The product register is the writer of this value; this block is its consumer.

---
 rtl/product_bcd_conv_pkg.sv | 18 +
 rtl/product_bcd_conv_if.sv | 31 +++
 rtl/product_bcd_conv_bcd_add3.sv | 17 +
 rtl/product_bcd_conv.sv | 130 +++++++++++++
 tb/tb_product_bcd_conv.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/product_bcd_conv_pkg.sv
// Shared types and constants for the signed-product to BCD converter.
// Digit correction thresholds and the FSM state encoding live here.
package product_bcd_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam logic [3:0] ADD3_THRESHOLD = 4'd5;
    localparam logic [3:0] ADD3_VALUE     = 4'd3;

    localparam int WIDTH_DEFAULT  = 14;
    localparam int DIGITS_DEFAULT = 5;
    localparam int CNT_W_DEFAULT  = $clog2(WIDTH_DEFAULT);

endpackage

// File: rtl/product_bcd_conv_if.sv
// Handshake and result bundle between the product register side and the converter.
// The master drives start/product; the converter (slave) returns status and digits.
interface product_bcd_conv_if #(
    parameter int WIDTH  = 14,
    parameter int DIGITS = 5
);
    logic                      start;
    logic signed [WIDTH-1:0]   product;
    logic                      busy;
    logic                      done;
    logic                      sign;
    logic [4*DIGITS-1:0]       bcd;

    modport master (
        output start,
        output product,
        input  busy,
        input  done,
        input  sign,
        input  bcd
    );

    modport slave (
        input  start,
        input  product,
        output busy,
        output done,
        output sign,
        output bcd
    );
endinterface

// File: rtl/product_bcd_conv_bcd_add3.sv
// Single-digit double-dabble correction: digits of five or more get three added
// so that the following left shift carries cleanly into the next decade.
module bcd_add3
    import product_bcd_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    always_comb begin
        dout = din;
        if (din >= ADD3_THRESHOLD) begin
            dout = din + ADD3_VALUE;
        end
    end

endmodule

// File: rtl/product_bcd_conv.sv
// Sequential double-dabble conversion of a signed product into sign plus packed BCD,
// one magnitude bit per clock, with a start/busy/done handshake.
module product_bcd_conv
    import product_bcd_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEFAULT,
    parameter int DIGITS = DIGITS_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    product_bcd_conv_if.slave   bus
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam int BCD_W = 4 * DIGITS;

    state_t                     state;
    state_t                     state_next;

    logic [CNT_W-1:0]           count;
    logic [WIDTH-1:0]           mag;
    logic [BCD_W-1:0]           scratch;
    logic [BCD_W-1:0]           scratch_adj;
    logic                       sign_q;

    logic                       done_r;
    logic                       sign_r;
    logic [BCD_W-1:0]           bcd_r;

    logic [WIDTH-1:0]           product_u;
    logic [WIDTH-1:0]           product_abs;

    // Magnitude is taken modulo 2^WIDTH, so the most negative input maps to
    // 2^(WIDTH-1) which still fits as an unsigned WIDTH-bit value.
    function automatic logic [WIDTH-1:0] abs_value(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        r = v;
        if (v[WIDTH-1]) begin
            r = ~v + WIDTH'(1);
        end
        return r;
    endfunction

    assign product_u   = bus.product;
    assign product_abs = abs_value(product_u);

    for (genvar d = 0; d < DIGITS; d++) begin : g_digit
        bcd_add3 u_add3 (
            .din  (scratch[4*d +: 4]),
            .dout (scratch_adj[4*d +: 4])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = CONVERT;
                end
            end
            CONVERT: begin
                if (count == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Scratch digits are corrected before every shift; the magnitude MSB
    // enters the units digit as the combined register moves left.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count   <= '0;
            mag     <= '0;
            scratch <= '0;
            sign_q  <= 1'b0;
            done_r  <= 1'b0;
            sign_r  <= 1'b0;
            bcd_r   <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        sign_q  <= product_u[WIDTH-1];
                        mag     <= product_abs;
                        scratch <= '0;
                        count   <= CNT_W'(WIDTH - 1);
                    end
                end
                CONVERT: begin
                    scratch <= {scratch_adj[BCD_W-2:0], mag[WIDTH-1]};
                    mag     <= {mag[WIDTH-2:0], 1'b0};
                    if (count != '0) begin
                        count <= count - CNT_W'(1);
                    end
                end
                DONE: begin
                    sign_r <= sign_q;
                    bcd_r  <= scratch;
                    done_r <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // The done cycle is already IDLE internally but is still reported busy.
    assign bus.busy = (state != IDLE) | done_r;
    assign bus.done = done_r;
    assign bus.sign = sign_r;
    assign bus.bcd  = bcd_r;

endmodule

// File: tb/tb_product_bcd_conv.sv
// Self-checking bench for product_bcd_conv: directed scenarios plus a randomized
// sweep compared against an arithmetic decimal model.
module tb_product_bcd_conv;

    localparam int WIDTH  = 14;
    localparam int DIGITS = 5;
    localparam int BCD_W  = 4 * DIGITS;
    localparam int LIMIT  = 40;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    product_bcd_conv_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

    product_bcd_conv #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void ref_model(input int v, output logic s, output logic [BCD_W-1:0] b);
        int m;
        s = (v < 0);
        m = (v < 0) ? -v : v;
        b = '0;
        for (int i = 0; i < DIGITS; i++) begin
            b[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
    endfunction

    task automatic kick(input int v);
        @(negedge clk);
        bus.start   = 1'b1;
        bus.product = 14'(v);
        @(negedge clk);
        bus.start   = 1'b0;
    endtask

    // Called one cycle after acceptance; returns cycle index at which done was seen.
    task automatic wait_done(output int lat);
        lat = 1;
        while (!bus.done && lat < LIMIT) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.product = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl busy=%b done=%b expected 0 0", bus.busy, bus.done);
        end
        checks++;
        if (bus.sign !== 1'b0 || bus.bcd !== 20'h00000) begin
            errors++;
            $display("FAIL reset_data sign=%b bcd=%h expected 0 00000", bus.sign, bus.bcd);
        end
    endtask

    task automatic test_latency;
        int lat;
        int busy_cnt;
        logic hold_ok;
        logic ps;
        logic [BCD_W-1:0] pb;
        ps = bus.sign;
        pb = bus.bcd;
        hold_ok = 1'b1;
        busy_cnt = 0;
        lat = LIMIT;
        kick(1234);
        for (int k = 1; k <= LIMIT; k++) begin
            if (bus.done) begin
                lat = k;
                break;
            end
            if (bus.busy) busy_cnt++;
            if (bus.sign !== ps || bus.bcd !== pb) hold_ok = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (lat != 16) begin
            errors++;
            $display("FAIL latency got %0d cycles expected 16", lat);
        end
        checks++;
        if (busy_cnt != 15 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_window got %0d cycles, busy_at_done=%b expected 15 and 1", busy_cnt, bus.busy);
        end
        checks++;
        if (!hold_ok) begin
            errors++;
            $display("FAIL hold_while_busy outputs changed before done, expected stable");
        end
        checks++;
        if (bus.sign !== 1'b0 || bus.bcd !== 20'h01234) begin
            errors++;
            $display("FAIL conv_1234 sign=%b bcd=%h expected 0 01234", bus.sign, bus.bcd);
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse done=%b busy=%b one cycle later, expected 0 0", bus.done, bus.busy);
        end
        checks++;
        if (bus.sign !== 1'b0 || bus.bcd !== 20'h01234) begin
            errors++;
            $display("FAIL hold_after_done sign=%b bcd=%h expected 0 01234", bus.sign, bus.bcd);
        end
    endtask

    task automatic test_boundaries;
        int vals [5];
        int lat;
        logic es;
        logic [BCD_W-1:0] eb;
        vals = '{-8192, 8191, -1, 0, -1};
        for (int i = 0; i < 5; i++) begin
            kick(vals[i]);
            wait_done(lat);
            ref_model(vals[i], es, eb);
            checks++;
            if (lat != 16 || bus.sign !== es || bus.bcd !== eb) begin
                errors++;
                $display("FAIL boundary_%0d lat=%0d sign=%b bcd=%h expected 16 %b %h",
                         vals[i], lat, bus.sign, bus.bcd, es, eb);
            end
        end
        kick(0);
        wait_done(lat);
        checks++;
        if (bus.sign !== 1'b0 || bus.bcd !== 20'h00000) begin
            errors++;
            $display("FAIL zero_clears_sign sign=%b bcd=%h expected 0 00000", bus.sign, bus.bcd);
        end
    endtask

    task automatic test_ignored_start;
        int dones;
        int first;
        dones = 0;
        first = 0;
        kick(1234);
        for (int k = 1; k <= LIMIT; k++) begin
            if (bus.done) begin
                dones++;
                if (first == 0) first = k;
            end
            if (k == 5 || k == 15) begin
                bus.start   = 1'b1;
                bus.product = -14'sd77;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        checks++;
        if (dones != 1 || first != 16) begin
            errors++;
            $display("FAIL ignored_start dones=%0d first=%0d expected 1 at 16", dones, first);
        end
        checks++;
        if (bus.sign !== 1'b0 || bus.bcd !== 20'h01234) begin
            errors++;
            $display("FAIL ignored_start_result sign=%b bcd=%h expected 0 01234", bus.sign, bus.bcd);
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        kick(-305);
        wait_done(lat);
        // done cycle: issue the next request immediately
        bus.start   = 1'b1;
        bus.product = 14'(4096);
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(lat);
        checks++;
        if (lat != 16 || bus.sign !== 1'b0 || bus.bcd !== 20'h04096) begin
            errors++;
            $display("FAIL back_to_back lat=%0d sign=%b bcd=%h expected 16 0 04096", lat, bus.sign, bus.bcd);
        end
    endtask

    task automatic test_reset_mid;
        int dones;
        int lat;
        dones = 0;
        kick(-500);
        for (int k = 1; k < 8; k++) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.sign !== 1'b0 || bus.bcd !== 20'h00000) begin
            errors++;
            $display("FAIL reset_mid busy=%b done=%b sign=%b bcd=%h expected 0 0 0 00000",
                     bus.busy, bus.done, bus.sign, bus.bcd);
        end
        for (int k = 0; k < 25; k++) begin
            if (bus.done) dones++;
            @(negedge clk);
        end
        checks++;
        if (dones != 0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_nodone dones=%0d busy=%b expected 0 0", dones, bus.busy);
        end
        kick(42);
        wait_done(lat);
        checks++;
        if (lat != 16 || bus.sign !== 1'b0 || bus.bcd !== 20'h00042) begin
            errors++;
            $display("FAIL after_reset_42 lat=%0d sign=%b bcd=%h expected 16 0 00042", lat, bus.sign, bus.bcd);
        end
    endtask

    task automatic test_random_sweep;
        int v;
        int lat;
        int bad;
        int digit_bad;
        logic es;
        logic [BCD_W-1:0] eb;
        bad = 0;
        digit_bad = 0;
        for (int n = 0; n < 1500; n++) begin
            v = int'($urandom_range(16383)) - 8192;
            kick(v);
            wait_done(lat);
            ref_model(v, es, eb);
            for (int d = 0; d < DIGITS; d++) begin
                if (bus.bcd[4*d +: 4] > 4'd9) digit_bad++;
            end
            checks++;
            if (lat != 16 || bus.sign !== es || bus.bcd !== eb) begin
                errors++;
                bad++;
                if (bad <= 10) begin
                    $display("FAIL sweep_%0d lat=%0d sign=%b bcd=%h expected 16 %b %h",
                             v, lat, bus.sign, bus.bcd, es, eb);
                end
            end
        end
        checks++;
        if (digit_bad != 0) begin
            errors++;
            $display("FAIL digit_range saw %0d digits above 9, expected 0", digit_bad);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.product = '0;
        test_reset;
        test_latency;
        test_boundaries;
        test_ignored_start;
        test_back_to_back;
        test_reset_mid;
        test_random_sweep;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
